// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard controller.
// Forward-select encodings, memory-wait FSM states and helpers.
package mips_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_wait_state_t;

    // E-stage operand select: M beats W, r0 is never forwarded.
    function automatic fwd_sel_t fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (src != REG_ZERO && rw_m && src == wr_m)
            sel = FWD_MEM;
        else if (src != REG_ZERO && rw_w && src == wr_w)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_mem_wait.sv
// Multicycle data-memory wait tracker with timeout.
// Freezes the pipeline on a miss; a timeout parks it in ERR.
module hazard_mem_wait
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_req_m,
    input  logic            mem_ready,
    output logic            memstall,
    output logic            mem_err,
    output mem_wait_state_t state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_wait_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: ready wins, dropped request aborts, else time out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_m && !mem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT: begin
                if (mem_ready || !mem_req_m) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: the freeze starts in the miss cycle itself.
    always_comb begin
        mem_err  = (state_q == ERR);
        memstall = mem_err || (mem_req_m && !mem_ready);
        state    = state_q;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and forwarding.
// Load-use and branch hazards plus a memory-wait freeze.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         rs_d,
    input  logic [4:0]         rt_d,
    input  logic               branch_d,
    input  logic [4:0]         rs_e,
    input  logic [4:0]         rt_e,
    input  logic [4:0]         writereg_e,
    input  logic [4:0]         writereg_m,
    input  logic [4:0]         writereg_w,
    input  logic               regwrite_e,
    input  logic               regwrite_m,
    input  logic               regwrite_w,
    input  logic               memtoreg_e,
    input  logic               memtoreg_m,
    input  logic               mem_req_m,
    input  logic               mem_ready,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               stall_m,
    output logic               flush_e,
    output logic               flush_w,
    output logic               forward_a_d,
    output logic               forward_b_d,
    output logic [1:0]         forward_a_e,
    output logic [1:0]         forward_b_e,
    output logic               mem_err,
    output logic [COUNT_W-1:0] stall_count
);

    logic            memstall;
    mem_wait_state_t wait_state;
    fwd_sel_t        fa_e, fb_e;
    logic            fa_d, fb_d;
    logic            lwstall, branchstall, hz;
    logic [COUNT_W-1:0] stall_count_q, stall_count_d;

    hazard_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait (
        .clk      (clk),
        .reset    (reset),
        .mem_req_m(mem_req_m),
        .mem_ready(mem_ready),
        .memstall (memstall),
        .mem_err  (mem_err),
        .state    (wait_state)
    );

    // Forwarding selects for the E operands and the D comparator.
    always_comb begin
        fa_e = fwd_sel(rs_e, regwrite_m, writereg_m,
                       regwrite_w, writereg_w);
        fb_e = fwd_sel(rt_e, regwrite_m, writereg_m,
                       regwrite_w, writereg_w);
        fa_d = (rs_d != REG_ZERO) && regwrite_m
               && (rs_d == writereg_m);
        fb_d = (rt_d != REG_ZERO) && regwrite_m
               && (rt_d == writereg_m);
    end

    // Load-use and branch-compare hazard detection.
    always_comb begin
        lwstall = memtoreg_e
                  && (rt_e == rs_d || rt_e == rt_d);
        branchstall = branch_d && (
            (regwrite_e
             && (writereg_e == rs_d || writereg_e == rt_d))
            || (memtoreg_m
             && (writereg_m == rs_d || writereg_m == rt_d)));
        hz = lwstall || branchstall;
    end

    // Control outputs: reset forces bubbles, freeze beats hz.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        forward_a_d = 1'b0;
        forward_b_d = 1'b0;
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (!reset) begin
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            forward_a_d = fa_d;
            forward_b_d = fb_d;
            forward_a_e = fa_e;
            forward_b_e = fb_e;
            if (memstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = hz;
                stall_d = hz;
                flush_e = hz;
            end
        end
    end

    // Saturating stalled-cycle count; ERR cycles are not counted.
    always_comb begin
        stall_count_d = stall_count_q;
        if ((stall_f || stall_m) && wait_state != ERR
            && stall_count_q != '1)
            stall_count_d = stall_count_q + COUNT_W'(1);
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count_q <= '0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Vector table for combinational paths, sequences for the FSM.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] writereg_e, writereg_m, writereg_w;
    logic branch_d, regwrite_e, regwrite_m, regwrite_w;
    logic memtoreg_e, memtoreg_m, mem_req_m, mem_ready;
    logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;
    logic forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic mem_err;
    logic [CW-1:0] stall_count;
    logic [11:0] outv;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m),
        .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m),
        .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mem_err(mem_err), .stall_count(stall_count)
    );

    // {sf,sd,se,sm,fe,fw,fad,fbd,fae[1:0],fbe[1:0]}
    assign outv = {stall_f, stall_d, stall_e, stall_m,
                   flush_e, flush_w, forward_a_d, forward_b_d,
                   forward_a_e, forward_b_e};

    typedef struct {
        string      nm;
        logic [31:0] v;
    } sb_t;

    typedef struct {
        string      nm;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       br_d, rw_e, rw_m, rw_w, mtr_e, mtr_m;
        logic [11:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[17];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input string nm,
        input logic [4:0] a_rs_d, input logic [4:0] a_rt_d,
        input logic a_br,
        input logic [4:0] a_rs_e, input logic [4:0] a_rt_e,
        input logic [4:0] a_wr_e, input logic [4:0] a_wr_m,
        input logic [4:0] a_wr_w,
        input logic a_rw_e, input logic a_rw_m, input logic a_rw_w,
        input logic a_mtr_e, input logic a_mtr_m,
        input logic [11:0] a_exp
    );
        vec_t v;
        v.nm = nm;
        v.rs_d = a_rs_d; v.rt_d = a_rt_d; v.br_d = a_br;
        v.rs_e = a_rs_e; v.rt_e = a_rt_e;
        v.wr_e = a_wr_e; v.wr_m = a_wr_m; v.wr_w = a_wr_w;
        v.rw_e = a_rw_e; v.rw_m = a_rw_m; v.rw_w = a_rw_w;
        v.mtr_e = a_mtr_e; v.mtr_m = a_mtr_m;
        v.exp = a_exp;
        return v;
    endfunction

    task automatic expect_v(input string nm, input logic [31:0] v);
        sb_t e;
        e.nm = nm;
        e.v  = v;
        sbq.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: got %0h with nothing expected", act);
        end else begin
            e = sbq.pop_front();
            n_vec++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL %s: got %0h expected %0h",
                         e.nm, act, e.v);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        expect_v(nm, exp);
        check(act);
    endtask

    task automatic clr_in();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        writereg_e = 0; writereg_m = 0; writereg_w = 0;
        branch_d = 0; regwrite_e = 0; regwrite_m = 0;
        regwrite_w = 0; memtoreg_e = 0; memtoreg_m = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    task automatic set_lu(input logic on);
        memtoreg_e = on;
        rt_e = 5'd8;
        rs_d = 5'd8;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clr_in();
        #2;
        chk("rst_outs", 32'(outv), 32'h0C0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vt[0]  = mk("fwd_a_mem", 0,0,0, 5,0, 0,5,5, 0,1,1, 0,0, 12'h008);
        vt[1]  = mk("fwd_a_wb",  0,0,0, 5,0, 0,5,5, 0,0,1, 0,0, 12'h004);
        vt[2]  = mk("fwd_a_rf",  0,0,0, 0,0, 0,5,5, 0,0,1, 0,0, 12'h000);
        vt[3]  = mk("fwd_r0",    0,0,0, 0,0, 0,0,0, 0,1,1, 0,0, 12'h000);
        vt[4]  = mk("fwd_b_mem", 0,0,0, 0,7, 0,7,7, 0,1,1, 0,0, 12'h002);
        vt[5]  = mk("fwd_b_wb",  0,0,0, 0,7, 0,7,7, 0,0,1, 0,0, 12'h001);
        vt[6]  = mk("fwd_a_d",   6,0,0, 0,0, 0,6,0, 0,1,0, 0,0, 12'h020);
        vt[7]  = mk("fwd_b_d",   0,6,0, 0,0, 0,6,0, 0,1,0, 0,0, 12'h010);
        vt[8]  = mk("fwd_d_off", 6,0,0, 0,0, 0,6,0, 0,0,0, 0,0, 12'h000);
        vt[9]  = mk("lu_rs",     8,3,0, 0,8, 0,0,0, 0,0,0, 1,0, 12'hC80);
        vt[10] = mk("lu_none",   9,3,0, 0,8, 0,0,0, 0,0,0, 1,0, 12'h000);
        vt[11] = mk("lu_rt",     9,3,0, 0,3, 0,0,0, 0,0,0, 1,0, 12'hC80);
        vt[12] = mk("br_e",      2,4,1, 0,0, 4,0,0, 1,0,0, 0,0, 12'hC80);
        vt[13] = mk("br_m",      2,4,1, 0,0, 0,4,0, 0,1,0, 0,1, 12'hC90);
        vt[14] = mk("br_none",   2,3,1, 0,0, 4,0,0, 1,0,0, 0,0, 12'h000);
        vt[15] = mk("br_off",    2,4,0, 0,0, 4,0,0, 1,0,0, 0,0, 12'h000);
        vt[16] = mk("br_e_norw", 4,0,1, 0,0, 4,0,0, 0,0,0, 0,0, 12'h000);

        clr_in();
        do_reset();

        // Combinational vectors, FSM idle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rs_d = vt[i].rs_d; rt_d = vt[i].rt_d;
            branch_d = vt[i].br_d;
            rs_e = vt[i].rs_e; rt_e = vt[i].rt_e;
            writereg_e = vt[i].wr_e; writereg_m = vt[i].wr_m;
            writereg_w = vt[i].wr_w;
            regwrite_e = vt[i].rw_e; regwrite_m = vt[i].rw_m;
            regwrite_w = vt[i].rw_w;
            memtoreg_e = vt[i].mtr_e; memtoreg_m = vt[i].mtr_m;
            expect_v(vt[i].nm, 32'(vt[i].exp));
            #2;
            check(32'(outv));
        end

        // Load-use count and saturation.
        do_reset();
        set_lu(1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) chk("lu_cnt2", 32'(stall_count), 32'd2);
            if (i == 10) chk("sat_cnt", 32'(stall_count), 32'd7);
        end

        // Memory wait of three cycles, load-use masked by freeze.
        do_reset();
        mem_req_m = 1; mem_ready = 0; set_lu(1'b1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_frz", 32'(outv), 32'hF40);
            @(negedge clk);
        end
        chk("mw_cnt3", 32'(stall_count), 32'd3);
        mem_ready = 1; set_lu(1'b0);
        #2;
        chk("mw_rel", 32'(outv), 32'h000);
        @(negedge clk);
        chk("mw_cnt_hold", 32'(stall_count), 32'd3);
        chk("mw_noerr", 32'(mem_err), 32'd0);
        set_lu(1'b1);
        #2;
        chk("mw_lu_after", 32'(outv), 32'hC80);

        // Request drop restarts the timeout.
        do_reset();
        mem_req_m = 1; mem_ready = 0;
        repeat (2) @(negedge clk);
        mem_req_m = 0;
        @(negedge clk);
        mem_req_m = 1;
        repeat (3) @(negedge clk);
        chk("drop_noerr", 32'(mem_err), 32'd0);

        // Timeout into ERR, then asynchronous reset.
        do_reset();
        mem_req_m = 1; mem_ready = 0;
        repeat (3) @(negedge clk);
        chk("to_pre", 32'(mem_err), 32'd0);
        @(negedge clk);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_frz", 32'(outv), 32'hF40);
        mem_ready = 1;
        #2;
        chk("err_ign_rdy", 32'(outv), 32'hF40);
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(mem_err), 32'd1);
        chk("err_cnt", 32'(stall_count), 32'd4);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_err", 32'(mem_err), 32'd0);
        chk("arst_cnt", 32'(stall_count), 32'd0);
        chk("arst_outs", 32'(outv), 32'h0C0);
        @(negedge clk);
        reset = 1'b1;
        clr_in();
        #2;
        chk("post_rst", 32'(outv), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It produces the stall, flush and forward controls that the decode/execute pipeline register and the other pipeline registers consume.
- It resolves load-use and branch-compare hazards and selects forwarding paths.
- It holds the whole pipeline frozen while the multicycle data memory is busy, with a timeout that raises a sticky error.
- It sits beside the datapath and reads register specifiers and control bits from the D, E, M and W stages.

Parameters:
MEM_TIMEOUT, 16, wait cycles allowed before mem_err is raised (must be ≥2).
COUNT_W, 32, width of the saturating stall-cycle counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
rs_d, rt_d  in  5 each  source registers in decode
branch_d  in  1  branch in decode (compare is done in D)
rs_e, rt_e  in  5 each  source registers in execute
writereg_e, writereg_m, writereg_w  in  5 each  destination registers per stage
regwrite_e, regwrite_m, regwrite_w  in  1 each  register-write enables per stage
memtoreg_e, memtoreg_m  in  1 each  load in execute / memory stage
mem_req_m  in  1  load or store active in M
mem_ready  in  1  data memory completes the access this cycle
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
flush_e, flush_w  out  1 each  bubble into E / W
forward_a_d, forward_b_d  out  1 each  forward ALU-out from M into the D comparator
forward_a_e, forward_b_e  out  2 each  E operand select: 00 register file, 01 W result, 10 M ALU-out
mem_err  out  1  sticky memory timeout flag
stall_count  out  COUNT_W  saturating count of stalled cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; wait counter, stall_count and mem_err clear to 0.
  - While reset is low, outputs are forced: flush_e=1, flush_w=1, all stall_*=0, all forward selects=0.
- Forwarding, combinational, register 0 never forwarded:
  - forward_a_e=10 if rs_e≠0 & regwrite_m & rs_e==writereg_m.
  - Otherwise forward_a_e=01 if rs_e≠0 & regwrite_w & rs_e==writereg_w.
  - Otherwise forward_a_e=00. M has priority over W.
  - forward_b_e is the same rule using rt_e.
  - forward_a_d = rs_d≠0 & regwrite_m & rs_d==writereg_m; forward_b_d is the same using rt_d.
- Hazard terms:
  - lwstall = memtoreg_e & (rt_e==rs_d | rt_e==rt_d).
  - branchstall = branch_d & ((regwrite_e & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m∈{rs_d,rt_d})).
  - hz = lwstall | branchstall.
- Memory wait, combinational:
  - memstall = (state≠ERR & mem_req_m & !mem_ready) | state==ERR.
- Output priority:
  - If memstall: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_e=0. The freeze overrides hz, so the E contents are kept.
  - Else: stall_f=stall_d=flush_e=hz; stall_e=stall_m=flush_w=0.
- Wait FSM and counter (registered):
  - IDLE: if mem_req_m & !mem_ready → WAIT, counter=1. Otherwise stay in IDLE.
  - WAIT:
    - mem_ready → IDLE, counter=0. Completion in the same cycle releases the stall in that cycle.
    - Otherwise, if counter==MEM_TIMEOUT-1 → ERR.
    - Otherwise counter+1.
    - If mem_req_m drops without ready → IDLE.
  - ERR: terminal until reset. mem_err=1 from the first ERR cycle. The pipeline stays frozen; mem_ready is ignored.
  - Stall latency is 0 cycles: memstall asserts in the same cycle as the miss.
- stall_count:
  - +1 on each clock edge where stall_f|stall_m=1 and state≠ERR.
  - Saturates at 2^COUNT_W−1, with no wrap.
- Simultaneous events:
  - A memstall during lwstall: only the freeze is applied. lwstall is re-evaluated after release.
  - Reset during WAIT or ERR: returns immediately to IDLE with all flags cleared.

Decomposition:
- Package mips_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mem_wait_state_t enum: IDLE, WAIT, ERR.
  - REG_ZERO=5'd0.
- One sub-module, hazard_mem_wait: the FSM plus timeout counter. It outputs memstall, mem_err and state.
- Forwarding, hazard logic and stall_count stay in hazard_ctrl.

Test Plan:
- Forwarding priority: rs_e=5, writereg_m=5, regwrite_m=1, writereg_w=5, regwrite_w=1 → forward_a_e=10. Set regwrite_m=0 → 01. Set rs_e=0 → 00.
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 → stall_f=stall_d=flush_e=1, stall_e=0, stall_count +1 per edge. rs_d=9, rt_d=3 → all 0.
- Branch hazard: branch_d=1, regwrite_e=1, writereg_e=4, rt_d=4 → stall_f=flush_e=1. Same with memtoreg_m=1, writereg_m=4 and regwrite_e=0 → stall asserted.
- Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles, then 1 → all four stall_*=1, flush_w=1, flush_e=0 for 3 cycles; released in the ready cycle; state returns to IDLE; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → ERR entered after 4 stalled cycles. mem_err=1 and stalls stay high even after mem_ready=1. Drive reset=0 mid-ERR → mem_err=0, stall_count=0, flush_e=1 while reset is low.
- Saturation: COUNT_W=3, continuous load-use stall for 10 cycles → stall_count stops at 7.
